// File: rtl/fetch_pc_gen.sv
// -----------------------------------------------------------------------------
// fetch_pc_gen
//   Fetch-stage PC generator. Produces the dual-fetch PC pair looked up by the
//   branch predictor and the I-cache request valid. It arbitrates the execute
//   redirect, the predictor redirect and the sequential PC. A prediction that
//   arrives while fetch cannot advance is parked until the next accepted fetch.
//
// Ports
//   clk            clock, all state on rising edge
//   rst            asynchronous active-high reset
//   stall          downstream stall, blocks PC advance (not the request)
//   br_bus         {br_e, br_target}   resolved redirect from execute
//   bp_bus         {bp_e, bp_target}   registered prediction from predictor
//   fetch_req      I-cache request valid (low only in the IDLE cycle)
//   fetch_addr_ok  I-cache accepts the request this cycle
//   current_pc1    PC of fetch slot 0
//   current_pc2    PC of fetch slot 1 (pc + 4)
//   pc2_valid      slot 1 belongs to this fetch group (group stays in 8 bytes)
//   fetch_flush    one-cycle pulse after an execute redirect
// -----------------------------------------------------------------------------
module fetch_pc_gen #(
    parameter logic [31:0] RESET_PC = 32'hbfc0_0000,
    parameter int          BR_WD    = 33
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic [BR_WD-1:0] br_bus,
    input  logic [BR_WD-1:0] bp_bus,
    output logic             fetch_req,
    input  logic             fetch_addr_ok,
    output logic [31:0]      current_pc1,
    output logic [31:0]      current_pc2,
    output logic             pc2_valid,
    output logic             fetch_flush
);

    typedef enum logic {IDLE, RUN} state_t;

    state_t      state;
    state_t      state_n;

    logic [31:0] pc;
    logic [31:0] pc_n;
    logic        pend_br_v;
    logic        pend_br_v_n;
    logic [31:0] pend_br_tgt;
    logic        pend_bp_v;
    logic        pend_bp_v_n;
    logic [31:0] pend_bp_tgt;
    logic [31:0] pend_bp_tgt_n;

    logic        br_e;
    logic [31:0] br_target;
    logic        bp_e;
    logic [31:0] bp_target;
    logic        accept;
    logic [31:0] seq_next;

    // Targets are word aligned; low bits are discarded on load.
    assign br_e      = br_bus[BR_WD-1];
    assign br_target = {br_bus[31:2], 2'b00};
    assign bp_e      = bp_bus[BR_WD-1];
    assign bp_target = {bp_bus[31:2], 2'b00};

    assign accept    = fetch_req & fetch_addr_ok & ~stall;

    // An odd-word PC fetches a single slot so the group never crosses 8 bytes.
    assign seq_next  = pc + (pc[2] ? 32'd4 : 32'd8);

    assign current_pc1 = pc;
    assign current_pc2 = pc + 32'd4;
    assign pc2_valid   = ~pc[2];

    // State machine: one IDLE cycle after reset, then RUN forever.
    always_comb begin
        state_n   = state;
        fetch_req = 1'b0;
        case (state)
            IDLE: begin
                state_n = RUN;
            end
            RUN: begin
                fetch_req = 1'b1;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // Next-PC arbitration and redirect parking.
    always_comb begin
        pc_n          = pc;
        pend_br_v_n   = pend_br_v;
        pend_bp_v_n   = pend_bp_v;
        pend_bp_tgt_n = pend_bp_tgt;

        if (br_e) begin
            // Execute redirect is authoritative: drop anything parked and any
            // same-cycle prediction.
            pc_n        = br_target;
            pend_br_v_n = 1'b0;
            pend_bp_v_n = 1'b0;
        end else if (pend_br_v && (accept || !fetch_req)) begin
            pc_n        = pend_br_tgt;
            pend_br_v_n = 1'b0;
        end else if (bp_e && accept) begin
            // A fresh prediction supersedes an older parked one.
            pc_n        = bp_target;
            pend_bp_v_n = 1'b0;
        end else if (pend_bp_v && accept) begin
            pc_n        = pend_bp_tgt;
            pend_bp_v_n = 1'b0;
        end else if (accept) begin
            pc_n        = seq_next;
        end

        // Park a prediction that could not be applied this cycle; a later one
        // overwrites the target.
        if (!br_e && bp_e && !accept && !pend_br_v) begin
            pend_bp_v_n   = 1'b1;
            pend_bp_tgt_n = bp_target;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            pc          <= RESET_PC;
            pend_br_v   <= 1'b0;
            pend_bp_v   <= 1'b0;
            fetch_flush <= 1'b0;
        end else begin
            state       <= state_n;
            pc          <= pc_n;
            pend_br_v   <= pend_br_v_n;
            pend_bp_v   <= pend_bp_v_n;
            fetch_flush <= br_e;
        end
    end

    // Parked targets are qualified by their valid bits and need no reset.
    // The branch slot is only ever filled across a reset release, which in
    // this implementation never happens, so its target simply holds.
    always_ff @(posedge clk) begin
        pend_bp_tgt <= pend_bp_tgt_n;
        pend_br_tgt <= pend_br_tgt;
    end

endmodule

// File: tb/tb_fetch_pc_gen.sv
module tb_fetch_pc_gen;

    localparam logic [31:0] RST_PC = 32'hbfc0_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic [32:0] br_bus;
    logic [32:0] bp_bus;
    logic        fetch_req;
    logic        fetch_addr_ok;
    logic [31:0] current_pc1;
    logic [31:0] current_pc2;
    logic        pc2_valid;
    logic        fetch_flush;

    int total = 0;
    int bad   = 0;

    // Reference model state
    logic [31:0] m_pc;
    logic        m_run;
    logic        m_pbp_v;
    logic [31:0] m_pbp_t;
    logic        m_flush;

    fetch_pc_gen #(.RESET_PC(RST_PC), .BR_WD(33)) dut (
        .clk          (clk),
        .rst          (rst),
        .stall        (stall),
        .br_bus       (br_bus),
        .bp_bus       (bp_bus),
        .fetch_req    (fetch_req),
        .fetch_addr_ok(fetch_addr_ok),
        .current_pc1  (current_pc1),
        .current_pc2  (current_pc2),
        .pc2_valid    (pc2_valid),
        .fetch_flush  (fetch_flush)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %08h want %08h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pc    = RST_PC;
        m_run   = 1'b0;
        m_pbp_v = 1'b0;
        m_pbp_t = 32'h0;
        m_flush = 1'b0;
    endtask

    task automatic check_model(input string tag);
        chk({tag, ".pc1"},   current_pc1, m_pc);
        chk({tag, ".pc2"},   current_pc2, m_pc + 32'd4);
        chk({tag, ".pc2v"},  {31'd0, pc2_valid},   {31'd0, (m_pc % 8) == 0});
        chk({tag, ".req"},   {31'd0, fetch_req},   {31'd0, m_run});
        chk({tag, ".flush"}, {31'd0, fetch_flush}, {31'd0, m_flush});
    endtask

    // One clock: predict the post-edge state from the rules, advance, compare.
    task automatic tick(input string tag);
        logic        be, pe, acc;
        logic [31:0] bt, pt, npc;
        logic        nv;
        logic [31:0] nt;
        be  = br_bus[32];
        pe  = bp_bus[32];
        bt  = br_bus[31:0] & ~32'd3;
        pt  = bp_bus[31:0] & ~32'd3;
        acc = m_run && fetch_addr_ok && !stall;
        npc = m_pc;
        nv  = m_pbp_v;
        nt  = m_pbp_t;
        if (be) begin
            npc = bt; nv = 1'b0;
        end else if (pe && acc) begin
            npc = pt; nv = 1'b0;
        end else if (m_pbp_v && acc) begin
            npc = m_pbp_t; nv = 1'b0;
        end else if (acc) begin
            npc = m_pc + (((m_pc / 4) % 2 == 1) ? 32'd4 : 32'd8);
        end
        if (!be && pe && !acc) begin
            nv = 1'b1; nt = pt;
        end
        @(posedge clk);
        #1;
        if (rst) begin
            model_reset();
        end else begin
            m_pc    = npc;
            m_pbp_v = nv;
            m_pbp_t = nt;
            m_run   = 1'b1;
            m_flush = be;
        end
        check_model(tag);
    endtask

    task automatic set_in(input logic s, input logic ok, input logic be, input logic [31:0] bt,
                          input logic pe, input logic [31:0] pt);
        stall         = s;
        fetch_addr_ok = ok;
        br_bus        = {be, bt};
        bp_bus        = {pe, pt};
    endtask

    initial begin
        rst = 1'b1;
        model_reset();
        set_in(0, 1, 0, 0, 0, 0);
        tick("rst");
        tick("rst");
        chk("rst_pc1",  current_pc1, RST_PC);
        chk("rst_pc2",  current_pc2, RST_PC + 32'd4);
        chk("rst_req",  {31'd0, fetch_req}, 32'd0);
        chk("rst_pc2v", {31'd0, pc2_valid}, 32'd1);
        rst = 1'b0;

        // Reset release: one IDLE cycle, then sequential 8-byte groups.
        chk("idle_req", {31'd0, fetch_req}, 32'd0);
        tick("rel0");
        chk("rel0_pc", current_pc1, 32'hbfc0_0000);
        tick("rel1");
        chk("rel1_pc", current_pc1, 32'hbfc0_0008);
        tick("rel2");
        chk("rel2_pc", current_pc1, 32'hbfc0_0010);

        // Odd-word redirect target.
        set_in(0, 1, 1, 32'h8000_0104, 0, 0);
        tick("odd");
        chk("odd_pc",    current_pc1, 32'h8000_0104);
        chk("odd_pc2v",  {31'd0, pc2_valid}, 32'd0);
        chk("odd_flush", {31'd0, fetch_flush}, 32'd1);
        set_in(0, 1, 0, 0, 0, 0);
        tick("odd_acc");
        chk("odd_acc_pc", current_pc1, 32'h8000_0108);

        // Stall with a single-cycle prediction that must be parked.
        set_in(1, 1, 0, 0, 1, 32'h8000_1000);
        tick("stall0");
        set_in(1, 1, 0, 0, 0, 0);
        tick("stall1");
        tick("stall2");
        chk("stall_pc", current_pc1, 32'h8000_0108);
        set_in(0, 1, 0, 0, 0, 0);
        tick("park");
        chk("park_pc", current_pc1, 32'h8000_1000);

        // Execute and predictor redirect together: execute wins, prediction dropped.
        set_in(0, 1, 1, 32'h8000_2000, 1, 32'h8000_3000);
        tick("both");
        chk("both_pc", current_pc1, 32'h8000_2000);
        set_in(0, 1, 0, 0, 0, 0);
        tick("both1");
        tick("both2");
        chk("both2_pc", current_pc1, 32'h8000_2010);

        // Redirect under cache backpressure plus stall.
        set_in(1, 0, 1, 32'h8000_4000, 0, 0);
        tick("bp0");
        chk("bp0_pc",    current_pc1, 32'h8000_4000);
        chk("bp0_flush", {31'd0, fetch_flush}, 32'd1);
        set_in(0, 0, 0, 0, 0, 0);
        tick("bp1");
        chk("bp1_flush", {31'd0, fetch_flush}, 32'd0);
        chk("bp1_pc",    current_pc1, 32'h8000_4000);
        set_in(0, 1, 0, 0, 0, 0);
        tick("bp2");
        chk("bp2_pc", current_pc1, 32'h8000_4008);

        // Wrap at top of address space, low target bits discarded.
        set_in(0, 1, 1, 32'hffff_fffb, 0, 0);
        tick("wrap0");
        chk("wrap0_pc", current_pc1, 32'hffff_fff8);
        set_in(0, 1, 0, 0, 0, 0);
        tick("wrap1");
        chk("wrap1_pc", current_pc1, 32'h0000_0000);

        // Asynchronous reset between edges.
        #3;
        rst = 1'b1;
        #1;
        model_reset();
        chk("arst_pc",    current_pc1, RST_PC);
        chk("arst_req",   {31'd0, fetch_req}, 32'd0);
        chk("arst_flush", {31'd0, fetch_flush}, 32'd0);
        tick("arst_hold");
        rst = 1'b0;
        tick("arst_idle");
        tick("arst_run");
        chk("arst_run_pc", current_pc1, 32'hbfc0_0008);

        // Randomized traffic.
        for (int i = 0; i < 500; i++) begin
            logic [31:0] bt, pt;
            bt = ($urandom_range(0, 9) == 0) ? 32'hffff_fff8 + $urandom_range(0, 7) : $urandom;
            pt = $urandom;
            set_in($urandom_range(0, 9) < 3, $urandom_range(0, 9) < 7,
                   $urandom_range(0, 19) == 0, bt,
                   $urandom_range(0, 6) == 0, pt);
            tick("rnd");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
